// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused over N clock cycles.
// IDLE -> SHIFT (N cycles) -> FIN (DONE pulse) -> IDLE.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic [N-1:0] S,
  output logic         C,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   s_q, s_d;
  logic           carry_q, carry_d;
  logic           c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           sum_bit;
  logic           cell_carry;
  logic [N-1:0]   sum_msb;
  logic [N-1:0]   acc_shift;

  always_comb begin
    sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    cell_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // New sum bit enters at the MSB; after N shifts bit 0 holds the LSB.
    sum_msb    = N'(sum_bit) << (N - 1);
    acc_shift  = (acc_q >> 1) | sum_msb;

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_shift;
        carry_d = cell_carry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          s_d     = acc_shift;
          c_d     = cell_carry;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S    = s_q;
  assign C    = c_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: N=8 and N=1 instances checked against
// plain integer addition, with DONE latency, BUSY length and S/C hold checks.
module tb_serial_adder;

  localparam int N8 = 8;
  localparam int N1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] s8;
  logic       c8, busy8, done8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic [0:0] s1;
  logic       c1, busy1, done1;

  typedef struct {
    int unsigned expv;
    int unsigned acc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int unsigned cycle = 0;
  logic        rst_seen = 1'b0;
  bit          armed = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned hold8 = 0;
  int unsigned hold1 = 0;
  int          bc8 = 0;
  int          bc1 = 0;

  serial_adder #(.N(N8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
    .S(s8), .C(c8), .BUSY(busy8), .DONE(done8)
  );

  serial_adder #(.N(N1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1), .CIN(cin1),
    .S(s1), .C(c1), .BUSY(busy1), .DONE(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    rst_seen <= !rst_n;
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Single monitor process: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_outputs8", {s8, c8, busy8, done8}, 64'd0);
      check("reset_outputs1", {s1, c1, busy1, done1}, 64'd0);
      q8.delete();
      q1.delete();
      hold8 = 0;
      hold1 = 0;
      bc8   = 0;
      bc1   = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (busy8) bc8++;
      if (q8.size() > 0 && cycle == q8[0].acc + N8) begin
        check("done8_latency", done8, 1);
        if (done8) begin
          check("sum8", {c8, s8}, q8[0].expv);
          check("busy8_cycles", bc8, N8);
          check("busy8_in_fin", busy8, 0);
        end
        hold8 = q8[0].expv;
        bc8   = 0;
        void'(q8.pop_front());
      end else begin
        check("no_spurious_done8", done8, 0);
        check("hold8", {c8, s8}, hold8);
      end

      if (busy1) bc1++;
      if (q1.size() > 0 && cycle == q1[0].acc + N1) begin
        check("done1_latency", done1, 1);
        if (done1) begin
          check("sum1", {c1, s1}, q1[0].expv);
          check("busy1_cycles", bc1, N1);
          check("busy1_in_fin", busy1, 0);
        end
        hold1 = q1[0].expv;
        bc1   = 0;
        void'(q1.pop_front());
      end else begin
        check("no_spurious_done1", done1, 0);
        check("hold1", {c1, s1}, hold1);
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input bit toggle);
    int unsigned acc;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk);
    #1;
    acc = cycle;
    q8.push_back('{int'(a) + int'(b) + int'(cin), acc});
    start8 = 1'b0;
    // Inputs (including START) wiggle through SHIFT and FIN without effect.
    repeat (N8 + 1) begin
      @(negedge clk);
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); start8 = 1'($urandom);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    $display("op8 a=%02h b=%02h cin=%0d accepted at edge %0d", a, b, cin, acc);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin);
    int unsigned acc;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    @(posedge clk);
    #1;
    acc = cycle;
    q1.push_back('{int'(a) + int'(b) + int'(cin), acc});
    @(negedge clk);
    a1 = ~a; b1 = ~b; cin1 = ~cin;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    $display("op1 a=%0d b=%0d cin=%0d accepted at edge %0d", a, b, cin, acc);
  endtask

  initial begin
    int unsigned acc;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h5A, 8'hA5, 1'b1, 1'b1);

    // START held high across two operations.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    acc = cycle;
    q8.push_back('{32'd7, acc});
    q8.push_back('{32'h100, acc + N8 + 2});
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    repeat (N8 + 2) @(posedge clk);
    #1 start8 = 1'b0;
    $display("held-start pair accepted at edges %0d and %0d", acc, acc + N8 + 2);
    repeat (N8 + 3) @(negedge clk);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a8 = 8'h37; b8 = 8'h91; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    acc = cycle;
    q8.push_back('{32'h37 + 32'h91 + 32'd1, acc});
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset during SHIFT of op accepted at edge %0d", acc);
    repeat (N8 + 3) @(negedge clk);

    op8(8'h37, 8'h91, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0]);
    end
    for (int i = 0; i < 8; i++) begin
      op1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q8.size() == 0 && q1.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
